// File: rtl/gpr_bypass_scoreboard.sv
// GPR bypass with youngest-first forwarding, long-unit countdown scoreboard and unified ID stall.
// Latency: forwarding and stall are combinational. Backpressure: o_stall holds ID/IF, and i_flush masks it.
module gpr_bypass_scoreboard #(
    parameter int NUM_RPORTS = 2,
    parameter int NUM_STAGES = 3,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LONG_LAT   = 4,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RPORTS*ADDR_W-1:0] i_raddr,
    input  logic [NUM_RPORTS-1:0]        i_rused,
    input  logic [NUM_RPORTS*DATA_W-1:0] i_rdata,
    input  logic [NUM_STAGES-1:0]        i_stg_wen,
    input  logic [NUM_STAGES-1:0]        i_stg_ready,
    input  logic [NUM_STAGES*ADDR_W-1:0] i_stg_waddr,
    input  logic [NUM_STAGES*DATA_W-1:0] i_stg_wdata,
    input  logic                         i_long_req,
    input  logic [ADDR_W-1:0]            i_long_waddr,
    input  logic                         i_flush,
    output logic [NUM_RPORTS*DATA_W-1:0] o_rdata,
    output logic                         o_stall,
    output logic                         o_long_busy,
    output logic [CNT_W-1:0]             o_stall_cnt
);

    localparam logic [7:0] CNT_INIT = 8'(LONG_LAT - 1);

    logic                  busy;
    logic [ADDR_W-1:0]     lwaddr;
    logic [7:0]            cnt;
    logic [NUM_RPORTS-1:0] port_haz;
    logic                  struct_haz;
    logic                  issue_acc;

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] dat;
        logic              hit;
        logic              fwd_haz;
        logic              long_haz;

        assign raddr = i_raddr[p*ADDR_W +: ADDR_W];

        // The first matching stage wins even when it is not ready, so an older
        // ready result can never shadow a younger pending write.
        always_comb begin
            hit     = 1'b0;
            fwd_haz = 1'b0;
            dat     = i_rdata[p*DATA_W +: DATA_W];
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (!hit && i_stg_wen[s]
                    && i_stg_waddr[s*ADDR_W +: ADDR_W] != '0
                    && i_stg_waddr[s*ADDR_W +: ADDR_W] == raddr) begin
                    hit = 1'b1;
                    if (i_stg_ready[s]) begin
                        dat = i_stg_wdata[s*DATA_W +: DATA_W];
                    end else begin
                        fwd_haz = 1'b1;
                    end
                end
            end
        end

        assign long_haz    = busy && (lwaddr != '0) && (lwaddr == raddr);
        assign port_haz[p] = i_rused[p] && (fwd_haz || long_haz);
        assign o_rdata[p*DATA_W +: DATA_W] = dat;
    end

    assign struct_haz  = i_long_req && busy;
    assign o_stall     = !i_flush && ((|port_haz) || struct_haz);
    assign issue_acc   = i_long_req && !o_stall && !i_flush;
    assign o_long_busy = busy;

    // Accept is only possible while idle, since a request during busy is a structural stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            lwaddr <= '0;
            cnt    <= '0;
        end else if (busy) begin
            if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end else begin
                busy <= 1'b0;
            end
        end else if (issue_acc) begin
            busy   <= 1'b1;
            lwaddr <= i_long_waddr;
            cnt    <= CNT_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stall_cnt <= '0;
        end else if (o_stall && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/gpr_bypass_scoreboard.md
Name: gpr_bypass_scoreboard

Overview:
- Parametrised successor to the single-cycle GPR bypass unit.
- Forwards results from NUM_STAGES in-flight pipeline stages to NUM_RPORTS ID read ports, with youngest-stage priority.
- Tracks one non-pipelined long-latency unit (MUL/DIV) with an internal countdown scoreboard.
- Raises a unified ID stall for data and structural hazards, and keeps a saturating stall-cycle performance counter.
- Sits between the register file read ports and the ID stage.

Parameters:
NUM_RPORTS, 2, number of ID read ports
NUM_STAGES, 3, forwarding sources; index 0 = youngest (EXE), ascending = older
DATA_W, 32, register data width
ADDR_W, 5, register address width; register 0 hard-wired zero
LONG_LAT, 4, long-unit latency in cycles; legal range 2..255
CNT_W, 32, stall counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_raddr  input  NUM_RPORTS*ADDR_W  ID read addresses; port p at [p*ADDR_W +: ADDR_W]
i_rused  input  NUM_RPORTS  port p actually consumed by the ID instruction
i_rdata  input  NUM_RPORTS*DATA_W  register file read data
i_stg_wen  input  NUM_STAGES  stage s holds a GPR-writing instruction
i_stg_ready  input  NUM_STAGES  stage s result is valid this cycle
i_stg_waddr  input  NUM_STAGES*ADDR_W  stage destination registers
i_stg_wdata  input  NUM_STAGES*DATA_W  stage result data
i_long_req  input  1  ID instruction requests long-unit issue
i_long_waddr  input  ADDR_W  destination register of the long op
i_flush  input  1  ID instruction is killed this cycle
o_rdata  output  NUM_RPORTS*DATA_W  bypassed read data
o_stall  output  1  hold ID/IF this cycle
o_long_busy  output  1  long unit occupied
o_stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Forwarding is combinational, per port p. Scan stages s = 0..NUM_STAGES-1 and take the first s with i_stg_wen[s] && waddr[s]!=0 && waddr[s]==raddr[p].
  - Match with i_stg_ready[s]=1: o_rdata[p] = wdata[s].
  - Match with i_stg_ready[s]=0: o_rdata[p] = i_rdata[p], and port p is hazarded. An older ready match must NOT be used.
  - No match, or raddr[p]==0: o_rdata[p] = i_rdata[p]; a nonzero i_rdata with raddr 0 passes through unaltered.
- Scoreboard registers: busy (1b), lwaddr (ADDR_W), cnt (8b). Reset: busy=0, lwaddr=0, cnt=0.
- Long hazard on port p: busy && lwaddr!=0 && lwaddr==raddr[p].
- Structural hazard: i_long_req && busy.
- Hazards count only if i_rused[p]=1.
- o_stall = !i_flush && (any port hazard || structural hazard). i_flush forces o_stall=0.
- Issue accept = i_long_req && !o_stall && !i_flush. On accept at a clock edge: busy<=1, lwaddr<=i_long_waddr, cnt<=LONG_LAT-1.
- While busy:
  - cnt != 0: cnt decrements each edge.
  - cnt == 0: busy<=0 at that edge.
  - busy therefore stays high for exactly LONG_LAT cycles after the accept edge.
- A request arriving in the last busy cycle stalls that cycle and is accepted the next cycle; there is no same-cycle handoff.
- After busy clears, the long result is presented through a stage input by the pipeline; this block does not hold data.
- Issue with i_long_waddr==0 still occupies the unit (structural) but creates no data hazard.
- i_flush does not disturb an already-busy unit.
- o_long_busy = busy.
- o_stall_cnt: reset 0; +1 on every edge where o_stall=1; holds at all-ones (saturates).
- Async reset mid-operation: all registers return to reset values immediately, and o_long_busy drops without a clock.

Test Plan:
- Priority: stage0 (wen=1, waddr=5, ready=1, 0xAAAA0000) and stage2 (waddr=5, 0x12345678); raddr0=5 -> o_rdata0=0xAAAA0000, o_stall=0.
- Load-use: stage0 waddr=7 ready=0, stage1 waddr=7 ready=1, raddr1=7, i_rused=2'b10 -> o_stall=1, o_rdata1=i_rdata1; with i_rused=2'b01 -> o_stall=0.
- Zero register: stage0 waddr=0 wdata=0xFFFFFFFF, raddr0=0, i_rdata0=0 -> o_rdata0=0, o_stall=0.
- Long op (LONG_LAT=4): accept waddr=9; next instruction reads r9 -> o_stall=1 for 4 cycles, then 0. o_stall_cnt=4. A second i_long_req during busy is accepted exactly on the cycle after busy falls.
- Flush and saturation: i_flush=1 with a hazard present -> o_stall=0 and no accept. CNT_W=3 with 10 stall cycles -> o_stall_cnt=7.
- Async reset while busy (cnt=2) -> o_long_busy=0 and o_stall_cnt=0 immediately. After release, reading the old lwaddr -> no stall.
